// File: rtl/demux_dispatcher.sv
// Routes input words to four single-entry channel buffers, either by explicit destination
// or round-robin, with a flush/drain sequence and an accepted-word counter.
module demux_dispatcher (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_dest,
  input  logic       mode,
  input  logic       flush,
  output logic       flush_done,
  output logic [3:0] out_data0,
  output logic [3:0] out_data1,
  output logic [3:0] out_data2,
  output logic [3:0] out_data3,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic [7:0] accept_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0][3:0] data_q, data_d;
  logic [3:0]      valid_q, valid_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [3:0] avail_s;
  logic [7:0] avail_dbl_s;
  logic [3:0] avail_rot_s;
  logic [1:0] rr_off_s;
  logic [1:0] tgt_s;
  logic       tgt_ok_s;
  logic       accept_s;

  // Target selection: rotate availability so bit k means slot rr_ptr+k, then take the lowest.
  always_comb begin
    avail_s     = ~valid_q | out_ready;
    avail_dbl_s = {avail_s, avail_s} >> rr_ptr_q;
    avail_rot_s = avail_dbl_s[3:0];
    casez (avail_rot_s)
      4'b???1: rr_off_s = 2'd0;
      4'b??10: rr_off_s = 2'd1;
      4'b?100: rr_off_s = 2'd2;
      4'b1000: rr_off_s = 2'd3;
      default: rr_off_s = 2'd0;
    endcase
    if (mode == 1'b0) begin
      tgt_s    = in_dest;
      tgt_ok_s = avail_s[in_dest];
    end else begin
      tgt_s    = rr_ptr_q + rr_off_s;
      tgt_ok_s = |avail_rot_s;
    end
    in_ready = (state_q == ST_RUN) && tgt_ok_s;
    accept_s = in_valid && in_ready;
  end

  // Buffer, pointer and counter next-state: consume first, then a load may refill the slot.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q & ~out_ready;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (accept_s) begin
      valid_d[tgt_s] = 1'b1;
      data_d[tgt_s]  = in_data;
      cnt_d          = cnt_q + 8'd1;
      if (mode == 1'b1) begin
        rr_ptr_d = tgt_s + 2'd1;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Flush sequencing; DRAIN waits on the registered valid vector.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (valid_q == 4'b0000) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      data_q   <= '0;
      valid_q  <= 4'b0000;
      rr_ptr_q <= 2'd0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign flush_done = (state_q == ST_DONE);
  assign out_valid  = valid_q;
  assign out_data0  = data_q[0];
  assign out_data1  = data_q[1];
  assign out_data2  = data_q[2];
  assign out_data3  = data_q[3];
  assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed bench for demux_dispatcher: a slot/queue level model is compared every cycle,
// plus literal expectations taken from the worked scenarios.
module tb_demux_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_dest = 2'd0;
  logic       mode = 1'b0;
  logic       flush = 1'b0;
  logic       flush_done;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'b0000;
  logic [7:0] accept_cnt;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  demux_dispatcher dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .mode(mode), .flush(flush), .flush_done(flush_done),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready), .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: per-slot occupancy and contents, pointer, count, phase 0=RUN 1=DRAIN 2=DONE.
  bit mv[4];
  int md[4];
  int mptr = 0, mcnt = 0, mph = 0;

  function automatic int pick();
    if (mode == 1'b0) begin
      return (!mv[in_dest] || out_ready[in_dest]) ? int'(in_dest) : -1;
    end
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (mptr + k) % 4;
      if (!mv[c] || out_ready[c]) return c;
    end
    return -1;
  endfunction

  function automatic int model_valid();
    int v;
    v = 0;
    for (int i = 0; i < 4; i++) if (mv[i]) v += (1 << i);
    return v;
  endfunction

  always @(posedge clk) begin
    int t;
    bit acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] = 1'b0;
        md[i] = 0;
      end
      mptr = 0; mcnt = 0; mph = 0;
    end else begin
      t = pick();
      acc = in_valid && (mph == 0) && (t >= 0);
      if (mph == 0) mph = flush ? 1 : 0;
      else if (mph == 1) mph = (model_valid() == 0) ? 2 : 1;
      else mph = 0;
      for (int i = 0; i < 4; i++) if (mv[i] && out_ready[i]) mv[i] = 1'b0;
      if (acc) begin
        mv[t] = 1'b1;
        md[t] = int'(in_data);
        mcnt = (mcnt + 1) % 256;
        if (mode) mptr = (t + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_in_ready", int'(in_ready), int'((mph == 0) && (pick() >= 0)));
      chk("m_out_valid", int'(out_valid), model_valid());
      chk("m_out_data0", int'(out_data0), md[0]);
      chk("m_out_data1", int'(out_data1), md[1]);
      chk("m_out_data2", int'(out_data2), md[2]);
      chk("m_out_data3", int'(out_data3), md[3]);
      chk("m_accept_cnt", int'(accept_cnt), mcnt);
      chk("m_flush_done", int'(flush_done), int'(mph == 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  int exp_ch[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    cyc();
    armed = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_accept_cnt", int'(accept_cnt), 0);
    chk("rst_flush_done", int'(flush_done), 0);

    // Round-robin with every consumer ready.
    mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      in_data = 4'(d);
      @(negedge clk);
      chk("rr_in_ready", int'(in_ready), 1);
      cyc();
      chk("rr_lane_valid", int'(out_valid[exp_ch[d-1]]), 1);
      case (exp_ch[d-1])
        0: chk("rr_lane_data", int'(out_data0), d);
        1: chk("rr_lane_data", int'(out_data1), d);
        2: chk("rr_lane_data", int'(out_data2), d);
        default: chk("rr_lane_data", int'(out_data3), d);
      endcase
    end
    in_valid = 1'b0;
    chk("rr_accept_cnt", int'(accept_cnt), 5);
    cyc();

    // Round-robin with stalled consumers, then one slot drains while refilled.
    do_reset();
    out_ready = 4'b0000; in_valid = 1'b1;
    for (int d = 6; d <= 9; d++) begin
      in_data = 4'(d);
      cyc();
    end
    chk("full_out_valid", int'(out_valid), 15);
    in_data = 4'd10;
    @(negedge clk);
    chk("full_in_ready", int'(in_ready), 0);
    #1 out_ready = 4'b0100;
    #1 chk("refill_in_ready", int'(in_ready), 1);
    cyc();
    chk("refill_out_valid", int'(out_valid), 15);
    chk("refill_data2", int'(out_data2), 10);
    chk("refill_data0", int'(out_data0), 6);
    chk("refill_cnt", int'(accept_cnt), 5);
    in_valid = 1'b0; out_ready = 4'b1111;
    cyc();
    chk("empty_out_valid", int'(out_valid), 0);

    // Directed mode blocked on a busy slot while others are empty.
    mode = 1'b0; in_dest = 2'd1; out_ready = 4'b0000; in_valid = 1'b1; in_data = 4'd3;
    cyc();
    in_data = 4'd4;
    @(negedge clk);
    chk("dir_blocked", int'(in_ready), 0);
    #1 out_ready = 4'b0010;
    #1 chk("dir_unblocked", int'(in_ready), 1);
    cyc();
    chk("dir_out_valid", int'(out_valid), 2);
    chk("dir_data1", int'(out_data1), 4);
    out_ready = 4'b0000;

    // Flush with a same-cycle accept, then drain.
    in_dest = 2'd3; in_data = 4'd5;
    cyc();
    flush = 1'b1; in_dest = 2'd0; in_data = 4'd6;
    @(negedge clk);
    chk("flush_accept_ready", int'(in_ready), 1);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", int'(in_ready), 0);
    chk("drain_out_valid", int'(out_valid), 11);
    chk("drain_flush_done", int'(flush_done), 0);
    #1 out_ready = 4'b1111;
    cyc();
    chk("drained_valid", int'(out_valid), 0);
    chk("drained_flush_done", int'(flush_done), 0);
    cyc();
    chk("done_pulse", int'(flush_done), 1);
    chk("done_in_ready", int'(in_ready), 0);
    flush = 1'b1;
    cyc();
    chk("back_run_done", int'(flush_done), 0);
    chk("back_run_ready", int'(in_ready), 1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_cnt", int'(accept_cnt), 9);
    cyc();
    chk("no_redrain_done", int'(flush_done), 0);

    // Counter wrap, then reset in the middle of a drain.
    do_reset();
    mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_data = 4'(i);
      cyc();
    end
    chk("wrap_cnt", int'(accept_cnt), 1);
    out_ready = 4'b0000; in_data = 4'd1;
    cyc();
    in_data = 4'd2;
    cyc();
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 7);
    chk("pre_rst_ready", int'(in_ready), 0);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_cnt", int'(accept_cnt), 0);
    chk("mid_rst_data1", int'(out_data1), 0);
    chk("mid_rst_done", int'(flush_done), 0);
    rst = 1'b0;
    chk("post_rst_ready", int'(in_ready), 1);
    in_valid = 1'b1; in_data = 4'd9;
    cyc();
    chk("post_rst_lane", int'(out_valid), 1);
    chk("post_rst_data0", int'(out_data0), 9);
    in_valid = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_dispatcher.md
DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_data  input  4  data word to distribute.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_dest  input  2  target channel, used only when mode=0.
REQ-008 mode  input  1  0 = directed by in_dest; 1 = round-robin.
REQ-009 flush  input  1  request drain of all channel buffers.
REQ-010 flush_done  output  1  one-cycle pulse: drain complete.
REQ-011 out_data0..out_data3  output  4 each  per-channel buffered data.
REQ-012 out_valid  output  4  bit i = out_data_i valid.
REQ-013 out_ready  input  4  bit i = channel i consumer accepts.
REQ-014 accept_cnt  output  8  count of accepted input words.

Function
REQ-015 Each channel i SHALL hold a 1-entry buffer (out_data_i, out_valid[i]); slot i is "available" when out_valid[i]=0 or out_ready[i]=1.
REQ-016 Target t: mode=0 -> t=in_dest; mode=1 -> first available channel scanning rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
REQ-017 in_ready SHALL be combinational: 1 only when state=RUN and a target exists and is available (mode=0: slot in_dest available; mode=1: any slot available); in_ready SHALL NOT depend on in_valid.
REQ-018 Accept = in_valid & in_ready; on accept, out_data_t <= in_data and out_valid[t] <= 1 at the next edge (latency 1 cycle).
REQ-019 out_valid[i]&out_ready[i] without a same-cycle load into i SHALL clear out_valid[i] next cycle; out_data_i holds its last value.
REQ-020 Simultaneous consume and load on the same slot SHALL keep out_valid[i]=1 with the new data; no word lost or duplicated.
REQ-021 Slots not targeted and not consumed SHALL hold value and valid unchanged; out_valid never drops without handshake (except reset).
REQ-022 rr_ptr (2 bits, internal) SHALL update to (t+1) mod 4 on every accept in mode=1 and SHALL hold in mode=0 and on non-accept cycles.
REQ-023 mode and in_dest changes SHALL take effect in the same cycle; rr_ptr is not cleared by a mode change.
REQ-024 accept_cnt SHALL increment by 1 per accept, wrapping 255 -> 0.
REQ-025 FSM states RUN, DRAIN, DONE; RUN & flush -> DRAIN; DRAIN & out_valid==0 (registered) -> DONE; DONE -> RUN unconditionally.
REQ-026 An accept in the same RUN cycle as flush SHALL complete; in_ready=0 in DRAIN and DONE.
REQ-027 flush_done=1 only while in DONE (exactly one cycle); flush asserted in DRAIN or DONE SHALL be ignored.
REQ-028 Output handshakes SHALL continue normally in DRAIN and DONE.

Reset
REQ-029 rst=1 at an edge SHALL force: state=RUN, out_valid=0000, out_data0..3=0, rr_ptr=0, accept_cnt=0, flush_done=0.
REQ-030 Reset SHALL override all concurrent events; buffered data is discarded, including mid-DRAIN.
REQ-031 in_ready during reset cycle SHALL reflect current (pre-reset) state; first accept possible on the cycle after rst deasserts.

Verification
REQ-032 mode=1, out_ready=1111, in_valid=1 with data 1,2,3,4,5 -> words land on channels 0,1,2,3,0; accept_cnt=5.
REQ-033 mode=1, out_ready=0000, 5 words offered -> channels 0..3 filled with first 4 words, in_ready=0 on 5th; set out_ready[2]=1 -> 5th word lands in channel 2 same cycle slot drains, out_valid stays 1111.
REQ-034 mode=0, in_dest=1, out_valid[1]=1, out_ready[1]=0 -> in_ready=0 although slots 0,2,3 empty; raise out_ready[1] -> new word loads, out_valid[1] stays 1.
REQ-035 Two words buffered, flush=1 with in_valid=1 same cycle -> that word accepted; in_ready=0 until flush_done; drain via out_ready -> flush_done high exactly 1 cycle after out_valid=0000 observed, then RUN.
REQ-036 Send 257 words -> accept_cnt=1 (wrap); assert rst with 3 slots full in DRAIN -> next cycle out_valid=0000, state RUN, accept_cnt=0, rr_ptr=0.
